// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the MIPS single-cycle datapath.
// Holds the PC and a word-addressed instruction memory, and presents the
// current instruction combinationally so its opcode can drive the control unit.
// A small FSM sequences program load, execution and a sticky fault halt.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | after reset; waits for prog_mode (load) or start (run)
//   PROG  | program-load port writes memory; PC parked at RESET_PC
//   RUN   | PC advances each cycle (stall / jump / branch / sequential)
//   HALT  | PC left the memory range; sticky until reset
module instr_fetch_unit #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          prog_mode,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          branch,
  input  logic                          zero,
  input  logic                          jump,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_plus4,
  output logic [31:0]                   instr,
  output logic [5:0]                    opcode,
  output logic                          fetch_valid,
  output logic                          addr_fault,
  output logic [1:0]                    state
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PROG = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;

  logic [31:0] mem [IMEM_DEPTH];

  logic        in_range;
  logic        valid_w;
  logic [31:0] rd_word;
  logic [31:0] instr_w;
  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;

  // Depth is a power of two, so "word index < depth" is just "upper bits zero".
  assign in_range   = (pc_q[31:AW+2] == '0);
  assign rd_word    = mem[pc_q[AW+1:2]];
  assign valid_w    = (state_q == S_RUN) && in_range;
  assign instr_w    = valid_w ? rd_word : 32'h0;
  assign pc_plus4_w = pc_q + 32'd4;
  assign br_off     = {{14{instr_w[15]}}, instr_w[15:0], 2'b00};
  assign br_tgt     = pc_plus4_w + br_off;
  assign jmp_tgt    = {pc_plus4_w[31:28], instr_w[25:0], 2'b00};

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign instr       = instr_w;
  assign opcode      = instr_w[31:26];
  assign fetch_valid = valid_w;
  assign addr_fault  = fault_q;
  assign state       = state_q;

  // Program-load writes; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_PROG) && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Next state, next PC and fault flag.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (prog_mode) begin
          state_d = S_PROG;
          pc_d    = RESET_PC;
        end else if (start) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
        end
      end
      S_PROG: begin
        if (!prog_mode) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (prog_mode) begin
          // The instruction in flight is abandoned.
          state_d = S_PROG;
          pc_d    = RESET_PC;
        end else if (!in_range) begin
          // PC freezes at the offending address for post-mortem.
          state_d = S_HALT;
          fault_d = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (jump) begin
          pc_d = jmp_tgt;
        end else if (branch && zero) begin
          pc_d = br_tgt;
        end else begin
          pc_d = pc_plus4_w;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, PC and fault registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the MIPS single-cycle datapath: holds the PC and an internal word-addressed instruction memory, and each cycle presents the current instruction so its opcode field (`instr[31:26]`) drives the control unit's `operation` input. It computes the next PC from the control unit's `Branch` output, the ALU zero flag and a jump request. A program-load port fills the memory before execution, and a small state machine sequences load, run and fault-halt.

## Interface
- `IMEM_DEPTH`, 64: instruction memory depth in 32-bit words; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: start address; word aligned and inside memory.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `prog_mode`  in  1  level; high requests program-load mode.
- `prog_we`  in  1  write strobe for the program-load port.
- `prog_addr`  in  $clog2(IMEM_DEPTH)  word index for the load write.
- `prog_data`  in  32  instruction word to write.
- `start`  in  1  single-cycle pulse; begins execution from `RESET_PC`.
- `stall`  in  1  holds the PC for the current cycle.
- `branch`  in  1  `Branch` output of the control unit.
- `zero`  in  1  ALU zero flag.
- `jump`  in  1  jump request.
- `pc`  out  32  current PC.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `instr`  out  32  current instruction word.
- `opcode`  out  6  equal to `instr[31:26]`; connects to the control unit's `operation`.
- `fetch_valid`  out  1  `instr` is a real fetched instruction.
- `addr_fault`  out  1  sticky flag: PC left the memory range.
- `state`  out  2  IDLE=0, PROG=1, RUN=2, HALT=3.

## Operation
- **States:**
  - IDLE: after reset. `prog_mode`=1 goes to PROG; `start`=1 goes to RUN.
  - PROG: memory writes enabled. `prog_mode`=0 returns to IDLE.
  - RUN: PC advances. `prog_mode`=1 goes to PROG; a fault goes to HALT.
  - HALT: sticky; only `reset` leaves it.
- **Priority within a cycle:** `reset` > `prog_mode` > `start`. `start` is ignored outside IDLE.
- **Memory writes:** occur only when `state`=PROG and `prog_we`=1, at `prog_addr`, on the clock edge. Writes in any other state are dropped. Memory contents are not cleared by `reset`.
- **Instruction read:** combinational, `mem[pc[$clog2(IMEM_DEPTH)+1:2]]`.
  - `instr` is forced to 32'h0 (nop, opcode 0) unless `state`=RUN and the PC is in range.
  - `fetch_valid` = (`state`=RUN) and PC in range.
- **PC in range:** `pc[31:2] < IMEM_DEPTH`.
- **Next PC in RUN (priority order):**
  1. `stall`=1: hold `pc`.
  2. `jump`=1: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  3. `branch & zero`: `pc_plus4 + {sext(instr[15:0]), 2'b00}`, 32-bit wrap.
  4. Otherwise: `pc_plus4`.
- **PC is loaded with `RESET_PC` on:**
  - `reset`;
  - entry to RUN from IDLE;
  - entry to PROG.
- **PC hold:** `pc` is held in IDLE, PROG and HALT.
- **Fault:** in RUN with the PC out of range:
  - `addr_fault` is set on the next edge and the state goes to HALT;
  - `pc` freezes at the offending value;
  - `instr`=0 and `fetch_valid`=0 in that same cycle.

## Timing
- **Reset values:**
  - `state`=IDLE, `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4;
  - `instr`=0, `opcode`=0;
  - `fetch_valid`=0, `addr_fault`=0.
- **Fetch latency:** zero cycles. `instr`/`opcode` follow `pc` combinationally within the same cycle.
- **Branch/jump latency:** one cycle. Inputs are sampled at edge N and the target appears on `pc` after edge N.
- **Start latency:** `start` sampled at edge N puts `state`=RUN after edge N, with `fetch_valid`=1 and `pc`=`RESET_PC` in cycle N+1.
- **Mode change:** `prog_mode` asserted mid-RUN takes effect at the next edge; the instruction in flight is abandoned. A `prog_we` in the same cycle as PROG entry is dropped, since the state is not yet PROG.
- **Stall:** `stall` with `jump` or `branch` set still holds the PC; the redirect is lost unless it is re-presented.
- **Wrap:** `pc_plus4` from 32'hFFFF_FFFC gives 0 (faults anyway if out of range).

## Test plan
- **Reset values:** reset 2 cycles -> `state`=0, `pc`=0, `instr`=0, `fetch_valid`=0, `addr_fault`=0.
- **Load and sequential run:** load words 0..2 = 32'h8C01_0000 (lw), 32'hAC01_0004 (sw), 32'h1000_0002 (beq); pulse `start` -> `opcode` = 6'b100011, 6'b101011, 6'b000100 on successive cycles; `pc` = 0, 4, 8.
- **Branch taken vs not:** at the beq (`pc`=8, offset 2), `branch`=1, `zero`=1 -> next `pc`=20; repeat with `zero`=0 -> next `pc`=12.
- **Jump and stall:** instr 32'h0800_0001 with `jump`=1 -> next `pc`=4. `stall`=1 for 3 cycles -> `pc` constant and `instr` unchanged.
- **Fault:** `IMEM_DEPTH`=64, run sequentially past word 63 -> at `pc`=256: `fetch_valid`=0, `instr`=0; next cycle `addr_fault`=1, `state`=HALT. `start` is then ignored; `reset` clears to IDLE.
- **Mode-change boundaries:**
  - `prog_we` with `state`=RUN writing addr 0 -> memory unchanged;
  - `prog_mode` raised mid-RUN at `pc`=12 -> next cycle `state`=PROG, `pc`=0;
  - `prog_mode` and `start` together in IDLE -> PROG.
